// File: rtl/button_conditioner_pkg.sv
// Shared state encoding and sizing helper for the push-button conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Counter width for a terminal count of n cycles; never narrower than 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_conditioner_sync.sv
// Two-flop synchroniser for asynchronous single-bit inputs, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push-button and emits a clean level plus one-cycle
// press, release and long-press pulses, all registered.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 100000,
  parameter int unsigned LONG_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int unsigned DB_W   = cnt_width(DB_CYCLES);
  localparam int unsigned LONG_W = cnt_width(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic              btn_sync;
  btn_state_t        state, state_d;
  logic [DB_W-1:0]   db_cnt, db_cnt_d;
  logic [LONG_W-1:0] long_cnt, long_cnt_d;
  logic              long_fired, long_fired_d;
  logic              level_d, press_d, release_d, long_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      db_cnt        <= '0;
      long_cnt      <= '0;
      long_fired    <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_d;
      db_cnt        <= db_cnt_d;
      long_cnt      <= long_cnt_d;
      long_fired    <= long_fired_d;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

  always_comb begin
    state_d      = state;
    db_cnt_d     = db_cnt;
    long_cnt_d   = long_cnt;
    long_fired_d = long_fired;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;

    case (state)
      IDLE: begin
        if (btn_sync) begin
          state_d  = PRESS_WAIT;
          db_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_d      = HELD;
          press_d      = 1'b1;
          long_cnt_d   = '0;
          long_fired_d = 1'b0;
        end else begin
          db_cnt_d = db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        // A release wins over a long-press terminal on the same edge.
        if (!btn_sync) begin
          state_d  = RELEASE_WAIT;
          db_cnt_d = '0;
        end else if (!long_fired && long_cnt == LONG_LAST) begin
          long_d       = 1'b1;
          long_fired_d = 1'b1;
        end else if (!long_fired) begin
          long_cnt_d = long_cnt + LONG_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // long_cnt is left frozen so a release bounce does not restart long timing.
        if (btn_sync) begin
          state_d  = HELD;
          db_cnt_d = '0;
        end else if (db_cnt == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_cnt + DB_W'(1);
        end
      end
    endcase

    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scenario bench for button_conditioner with DB_CYCLES=4, LONG_CYCLES=10.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Expected {btn_level, press_pulse, release_pulse, long_pulse} per edge.
  logic [3:0] exp_q[$];

  button_conditioner #(
    .DB_CYCLES   (4),
    .LONG_CYCLES (10)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .btn_level     (btn_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {btn_level, press_pulse, release_pulse, long_pulse};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got lvl/prs/rel/lng=%b, expected %b", tag, got, exp);
    end
  endtask

  // Hold reset with the given btn_in level; outputs must be 0 at once and stay 0.
  task automatic apply_reset(input logic btn);
    @(negedge clk);
    rst_n  = 1'b0;
    btn_in = btn;
    #1 check("reset_async", outs(), 4'b0000);
    repeat (2) begin
      @(posedge clk);
      #1 check("reset_hold", outs(), 4'b0000);
    end
  endtask

  // Edge k samples btn_in high when k is in [hi_s,hi_e) but not in [g_s,g_e).
  // Expected events are edge numbers taken directly from the scenario; -1 = never.
  task automatic run(input string tag, input int n,
                     input int hi_s, input int hi_e, input int g_s, input int g_e,
                     input int p, input int l, input int r,
                     input int lv_s, input int lv_e);
    logic [3:0] exp;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n  = 1'b1;
      btn_in = (k >= hi_s && k < hi_e) && !(k >= g_s && k < g_e);
      exp_q.push_back({(k >= lv_s && k < lv_e), (k == p), (k == r), (k == l)});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("%s@e%0d", tag, k), outs(), exp);
    end
  endtask

  initial begin
    // 1: button held through reset release counts as a fresh press.
    apply_reset(1'b1);
    run("held_thru_reset", 20, 0, 1000, -1, -1, 6, 16, -1, 6, 1000);

    // 2: short bounce is rejected.
    apply_reset(1'b0);
    run("bounce", 14, 0, 3, -1, -1, -1, -1, -1, -1, -1);

    // 3: full press, long press, release.
    apply_reset(1'b0);
    run("full_cycle", 32, 0, 20, -1, -1, 6, 16, 26, 6, 26);

    // 4: release bounce after long press: no release, no second press.
    apply_reset(1'b0);
    run("rel_bounce", 72, 0, 60, 30, 32, 6, 16, 66, 6, 66);

    // 5: release lands on the long terminal edge: release wins.
    apply_reset(1'b0);
    run("rel_vs_long", 26, 0, 14, -1, -1, 6, -1, 20, 6, 20);

    // Release bounce before long fires: long_cnt frozen for 3 edges.
    apply_reset(1'b0);
    run("long_freeze", 40, 0, 30, 10, 12, 6, 19, 36, 6, 36);

    // 6: async reset mid-cycle while HELD with press_pulse high.
    apply_reset(1'b1);
    run("pre_async", 7, 0, 1000, -1, -1, 6, -1, -1, 6, 1000);
    #2 rst_n = 1'b0;
    #1 check("async_mid_cycle", outs(), 4'b0000);
    apply_reset(1'b1);
    run("after_async", 12, 0, 1000, -1, -1, 6, -1, -1, 6, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
